// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory bus arbiter.
//   arb_state_t : arbiter FSM states (IDLE -> ACCESS -> RESP)
//   owner_t     : index of a bus master (0 = CPU, 1 = debug/loader)
//   bus_req_t   : one master's access fields at the default widths
//   other_owner : the master that is not the given one
package dmem_arb_pkg;

  localparam int DEF_ADDR_W    = 8;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_MAX_BURST = 4;
  localparam int BURST_W       = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  typedef logic owner_t;

  typedef struct packed {
    logic                  we;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } bus_req_t;

  function automatic owner_t other_owner(input owner_t o);
    return ~o;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// Combinational winner selection for the two-master arbiter.
// Ports:
//   req0, req1  : request lines of master 0 / master 1
//   last_owner  : master that completed the most recent access
//   lock        : master 1 asks to keep ownership across accesses
//   burst_cnt   : locked master-1 grants made while master 0 waited
//   any_req     : at least one request is pending
//   winner      : master to grant when any_req is high
module rr_pick
  import dmem_arb_pkg::*;
#(
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic               req0,
  input  logic               req1,
  input  owner_t             last_owner,
  input  logic               lock,
  input  logic [BURST_W-1:0] burst_cnt,
  output logic               any_req,
  output owner_t             winner
);

  localparam logic [BURST_W-1:0] MAX_B = BURST_W'(MAX_BURST);

  always_comb begin
    any_req = req0 | req1;
    winner  = 1'b0;
    if (req0 && req1) begin
      // A locked master-1 burst may keep the bus only while it is still
      // under its budget; otherwise alternate.
      if ((last_owner == 1'b1) && lock && (burst_cnt < MAX_B)) begin
        winner = 1'b1;
      end else begin
        winner = other_owner(last_owner);
      end
    end else if (req1) begin
      winner = 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter in front of the data-memory / MMIO decoder.
// Every access runs IDLE -> ACCESS -> RESP (3 cycles); requests are only
// accepted in IDLE. Round-robin between masters, with an optional bounded
// lock that lets master 1 burst while master 0 waits.
// Ports:
//   clk, reset            : clock (rising edge), async active-low reset
//   mN_req/we/addr/wdata  : master N request and access fields
//   mN_gnt                : 1-cycle pulse in the ACCESS cycle of N's access
//   mN_rvalid             : 1-cycle pulse in the RESP cycle (reads and writes)
//   mN_rdata              : last data read by master N
//   m1_lock               : master 1 requests back-to-back ownership
//   mem_we/addr/wdata     : downstream bus (mem_we only high in ACCESS)
//   mem_rdata             : downstream read data, combinational from mem_addr
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  input  logic              m1_lock,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [BURST_W-1:0] MAX_B = BURST_W'(MAX_BURST);

  arb_state_t         state_reg, state_next;
  owner_t             owner_reg;
  owner_t             last_owner_reg;
  owner_t             winner;
  logic               any_req;
  logic               grant_now;
  logic [BURST_W-1:0] burst_cnt_reg, burst_cnt_next;

  // Fields of the access in flight; they also drive the downstream bus,
  // which is why mem_addr/mem_wdata hold their value between accesses.
  logic               lat_we_reg;
  logic [ADDR_W-1:0]  lat_addr_reg;
  logic [DATA_W-1:0]  lat_wdata_reg;

  logic [1:0]              gnt_vec;
  logic [1:0]              rvalid_vec;
  logic [1:0][DATA_W-1:0]  rdata_reg;

  rr_pick #(
    .MAX_BURST (MAX_BURST)
  ) u_rr_pick (
    .req0       (m0_req),
    .req1       (m1_req),
    .last_owner (last_owner_reg),
    .lock       (m1_lock),
    .burst_cnt  (burst_cnt_reg),
    .any_req    (any_req),
    .winner     (winner)
  );

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    grant_now  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          state_next = ACCESS;
          grant_now  = 1'b1;
        end
      end
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Burst budget: counts master-1 grants that kept master 0 waiting.
  // Any master-0 grant, or a master-1 grant without lock, ends the burst.
  always_comb begin
    burst_cnt_next = burst_cnt_reg;
    if (grant_now) begin
      if ((winner == 1'b0) || !m1_lock) begin
        burst_cnt_next = '0;
      end else if (m0_req && (burst_cnt_reg < MAX_B)) begin
        burst_cnt_next = burst_cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      owner_reg      <= 1'b0;
      last_owner_reg <= 1'b1;  // master 0 wins the first tie
      burst_cnt_reg  <= '0;
      lat_we_reg     <= 1'b0;
      lat_addr_reg   <= '0;
      lat_wdata_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      burst_cnt_reg <= burst_cnt_next;
      if (grant_now) begin
        owner_reg     <= winner;
        lat_we_reg    <= winner ? m1_we    : m0_we;
        lat_addr_reg  <= winner ? m1_addr  : m0_addr;
        lat_wdata_reg <= winner ? m1_wdata : m0_wdata;
      end
      if (state_reg == RESP) begin
        last_owner_reg <= owner_reg;
      end
    end
  end

  // Per-master handshake pulses
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_master
      assign gnt_vec[gi]    = (state_reg == ACCESS) && (owner_reg == owner_t'(gi));
      assign rvalid_vec[gi] = (state_reg == RESP)   && (owner_reg == owner_t'(gi));
    end
  endgenerate

  // Read data is captured only on reads, so a master's rdata survives its
  // own writes and the other master's traffic.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_reg <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (gnt_vec[i] && !lat_we_reg) begin
          rdata_reg[i] <= mem_rdata;
        end
      end
    end
  end

  assign m0_gnt    = gnt_vec[0];
  assign m1_gnt    = gnt_vec[1];
  assign m0_rvalid = rvalid_vec[0];
  assign m1_rvalid = rvalid_vec[1];
  assign m0_rdata  = rdata_reg[0];
  assign m1_rdata  = rdata_reg[1];

  assign mem_we    = (state_reg == ACCESS) && lat_we_reg;
  assign mem_addr  = lat_addr_reg;
  assign mem_wdata = lat_wdata_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we, m1_lock;
  logic [7:0]  m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_gnt    (m0_gnt),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata),
    .m1_lock   (m1_lock),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Memory model: preloaded pattern, overridden by writes
  bit [31:0] wr_data  [256];
  bit        wr_valid [256];

  function automatic logic [31:0] preload(input logic [7:0] a);
    return (a == 8'h10) ? 32'hDEADBEEF : {24'hC0FFEE, a};
  endfunction

  always @(posedge clk) begin
    if (mem_we) begin
      wr_data[mem_addr]  <= mem_wdata;
      wr_valid[mem_addr] <= 1'b1;
    end
  end

  assign mem_rdata = wr_valid[mem_addr] ? wr_data[mem_addr] : preload(mem_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [5:0] burst_order;
    logic [3:0] burst_exp [6];
    reset = 1'b0;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    m1_lock = 0;

    // Reset state
    tick(); tick();
    chk("rst_m0_gnt", m0_gnt, 0);
    chk("rst_m1_gnt", m1_gnt, 0);
    chk("rst_m0_rvalid", m0_rvalid, 0);
    chk("rst_m1_rvalid", m1_rvalid, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_m0_rdata", m0_rdata, 0);
    chk("rst_m1_rdata", m1_rdata, 0);
    reset = 1'b1;
    $display("reset checked");

    // Tie out of reset: m0,m1,m0,m1, 3 cycles each
    m0_req = 1; m0_addr = 8'h01;
    m1_req = 1; m1_addr = 8'h02;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("tie_gnt0", m0_gnt, (k % 2) == 0);
      chk("tie_gnt1", m1_gnt, (k % 2) == 1);
      tick();
      chk("tie_rvalid0", m0_rvalid, (k % 2) == 0);
      chk("tie_rvalid1", m1_rvalid, (k % 2) == 1);
      if ((k % 2) == 0) chk("tie_rdata0", m0_rdata, 32'hC0FFEE01);
      else              chk("tie_rdata1", m1_rdata, 32'hC0FFEE02);
      tick();
      chk("tie_idle_gnt", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}, 0);
      $display("tie access %0d owner m%0d", k, k % 2);
    end
    m0_req = 0; m1_req = 0;

    // Single read by m0
    m0_req = 1; m0_we = 0; m0_addr = 8'h10;
    tick();
    chk("rd_gnt", m0_gnt, 1);
    chk("rd_mem_we", mem_we, 0);
    chk("rd_mem_addr", mem_addr, 8'h10);
    m0_req = 0;
    tick();
    chk("rd_rvalid", m0_rvalid, 1);
    chk("rd_rdata", m0_rdata, 32'hDEADBEEF);
    chk("rd_gnt_off", m0_gnt, 0);
    tick();
    chk("rd_rvalid_off", m0_rvalid, 0);
    $display("m0 read 0x10 -> %h", m0_rdata);

    // Single write by m1
    m1_req = 1; m1_we = 1; m1_addr = 8'h80; m1_wdata = 32'h00000ABC;
    tick();
    chk("wr_gnt", m1_gnt, 1);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_addr", mem_addr, 8'h80);
    chk("wr_mem_wdata", mem_wdata, 32'h00000ABC);
    m1_req = 0; m1_we = 0;
    tick();
    chk("wr_mem_we_off", mem_we, 0);
    chk("wr_rvalid", m1_rvalid, 1);
    chk("wr_stored", wr_data[8'h80], 32'h00000ABC);
    tick();
    chk("wr_rvalid_off", m1_rvalid, 0);
    chk("wr_addr_hold", mem_addr, 8'h80);
    chk("wr_rdata_hold", m1_rdata, 32'hC0FFEE02);
    $display("m1 write 0x80 <- 0xabc");

    // Locked burst: m0, m1 x4, m0
    reset = 1'b0; tick(); reset = 1'b1;
    burst_order = 6'b011110;  // bit i = owner of grant i (LSB first)
    burst_exp[0] = 0; burst_exp[1] = 1; burst_exp[2] = 2;
    burst_exp[3] = 3; burst_exp[4] = 4; burst_exp[5] = 0;
    m0_req = 1; m0_addr = 8'h03;
    m1_req = 1; m1_addr = 8'h04;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("burst_gnt0", m0_gnt, !burst_order[i]);
      chk("burst_gnt1", m1_gnt, burst_order[i]);
      chk("burst_cnt", dut.burst_cnt_reg, burst_exp[i]);
      if (i == 0) m1_lock = 1;
      tick();
      tick();
      $display("burst grant %0d owner m%0d cnt %0d", i, burst_order[i], burst_exp[i]);
    end
    m0_req = 0; m1_req = 0; m1_lock = 0;

    // Reset in the middle of a write
    m1_req = 1; m1_we = 1; m1_addr = 8'h20; m1_wdata = 32'h55;
    tick();
    chk("rstw_mem_we", mem_we, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("rstw_mem_we_drop", mem_we, 0);
    chk("rstw_gnt_drop", m1_gnt, 0);
    chk("rstw_addr_clr", mem_addr, 0);
    m1_req = 0; m1_we = 0;
    tick();
    chk("rstw_no_write", wr_valid[8'h20], 0);
    chk("rstw_state", dut.state_reg, IDLE);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rstw_no_rvalid", {m0_rvalid, m1_rvalid}, 0);
    end
    m0_req = 1; m0_addr = 8'h05;
    m1_req = 1; m1_addr = 8'h06;
    tick();
    chk("rstw_tie_gnt0", m0_gnt, 1);
    chk("rstw_tie_gnt1", m1_gnt, 0);
    m0_req = 0; m1_req = 0;
    tick(); tick();
    $display("reset mid-write checked");

    // Lock without contention: 3 back-to-back m1 accesses
    m1_lock = 1; m1_req = 1; m1_addr = 8'h07;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("nolock_gnt", m1_gnt, 1);
      chk("nolock_cnt", dut.burst_cnt_reg, 0);
      tick();
      chk("nolock_rvalid", m1_rvalid, 1);
      tick();
      chk("nolock_idle", m1_gnt, 0);
      $display("uncontended m1 access %0d", i);
    end
    m1_req = 0; m1_lock = 0;
    chk("nolock_rdata", m1_rdata, 32'hC0FFEE07);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-master arbiter for the single data-memory bus: 8-bit word address, 32-bit data, decoded below it into DMEM and memory-mapped IO.
- Master 0 is the CPU load/store path. Master 1 is a debug/loader engine that fills DMEM and pokes IO registers.
- Each access is a req/gnt/rvalid handshake. Round-robin fairness, plus an optional bounded lock for master-1 bursts.
- Sits between the masters and the memory decoder. The downstream port has a combinational read.

Parameters:
- ADDR_W, 8, downstream address width
- DATA_W, 32, data width
- MAX_BURST, 4, maximum consecutive locked grants to master 1 while master 0 is waiting (1..15)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- m0_req  in  1  master 0 access request
- m0_we  in  1  master 0 write enable
- m0_addr  in  ADDR_W  master 0 address
- m0_wdata  in  DATA_W  master 0 write data
- m0_gnt  out  1  master 0 request accepted (1-cycle pulse)
- m0_rvalid  out  1  master 0 access complete, rdata valid (1-cycle pulse)
- m0_rdata  out  DATA_W  master 0 read data
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as master 0, for master 1
- m1_lock  in  1  master 1 requests back-to-back ownership
- mem_we  out  1  downstream write enable
- mem_addr  out  ADDR_W  downstream address
- mem_wdata  out  DATA_W  downstream write data
- mem_rdata  in  DATA_W  downstream read data, combinational from mem_addr

Behaviour:
- FSM states: IDLE, ACCESS, RESP. Each access takes exactly 3 cycles. A new request is accepted only in IDLE.
- IDLE:
  - If any req is high, pick a winner.
  - On the clock edge, latch the winner's we/addr/wdata, set owner, go to ACCESS.
  - If no req is high, stay in IDLE.
- ACCESS:
  - mem_addr/mem_wdata come from the latched fields. mem_we = latched we, asserted only in this state.
  - The owner's gnt is high for this cycle only.
  - mem_rdata is captured into the owner's rdata register at the end of the cycle.
  - Go to RESP.
- RESP:
  - The owner's rvalid is high for 1 cycle, for both reads and writes (writes: rvalid is the completion ack; rdata is undefined, whatever was captured).
  - Update last_owner, then return to IDLE.
- Masters hold req and fields stable until they see gnt. A req still high in the IDLE cycle after RESP is a new request.
- Arbitration when only one req is high: that master wins.
- Arbitration when both are high:
  - Default: the winner is the master that is not last_owner.
  - Lock override: master 1 wins when last_owner==1, m1_lock==1 and burst_cnt < MAX_BURST.
- burst_cnt (4 bits):
  - Increments on each master-1 grant made while m0_req is high.
  - Clears on any master-0 grant, or when m1_lock is low at a master-1 grant.
  - Saturates at MAX_BURST.
- mem_addr/mem_wdata hold their last values outside ACCESS. mem_we is 0 outside ACCESS.
- rdata registers hold until that master's next read completes.
- Reset values: state=IDLE, last_owner=1 (so master 0 wins the first tie), burst_cnt=0, all gnt/rvalid=0, mem_we=0, mem_addr=0, mem_wdata=0, m0_rdata=m1_rdata=0.
- Reset mid-operation: all outputs go to reset values immediately (asynchronous). The in-flight access is abandoned with no rvalid. A write is not performed unless the clock edge already occurred with mem_we high.
- m1_lock with no competing m0_req has no effect; plain single-requester service applies.

Decomposition:
- Shared package dmem_arb_pkg:
  - enum arb_state_t {IDLE, ACCESS, RESP}
  - typedef owner_t (1 bit)
  - typedef bus_req_t struct {we, addr, wdata}
  - default widths as localparams
- One sub-module, rr_pick, is natural: combinational winner selection from {req0, req1, last_owner, lock, burst_cnt}.
- The FSM, latches and counters stay in the top level.

Test Plan:
- Single read: m0 reads addr 0x10, DMEM holds 0xDEADBEEF → m0_gnt in cycle 1, mem_we=0, mem_addr=0x10; m0_rvalid in cycle 2 with m0_rdata=0xDEADBEEF.
- Single write: m1 writes 0x00000ABC to addr 0x80 (IO LED) → mem_we high for exactly 1 cycle with mem_addr=0x80 and mem_wdata=0xABC; m1_rvalid 1 cycle later.
- Tie out of reset: m0 and m1 both request continuously with no lock → grant order m0,m1,m0,m1; every access takes 3 cycles.
- Locked burst: m1_lock=1 and m0_req held high, MAX_BURST=4 → grant order m0,m1,m1,m1,m1,m0; burst_cnt saturates at 4, then clears on the m0 grant.
- Reset mid-write: assert reset during ACCESS → mem_we drops to 0 immediately; no rvalid afterwards; state=IDLE; a tie after release grants m0 first.
- Lock without contention: m1_lock=1, m1 requests 3 times, m0 idle → 3 back-to-back m1 accesses at 3-cycle spacing; burst_cnt stays 0.
